// File: rtl/puf_challenge_gen_pkg.sv
// puf_pkg: definitions shared by the PDL PUF challenge generator and the
// response-whitening logic that reuses the LFSR step.
//   state_t        - challenge generator FSM states
//   LFSR_TAPS_64   - feedback mask for x^64+x^63+x^61+x^60+1
//   LFSR_ZERO_SUB  - replacement for an all-zero seed (LFSR lock-up state)
//   lfsr_taps()    - feedback mask table indexed by register width
package puf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Bit i of a mask set means c[i] feeds the XOR that becomes the new LSB.
  localparam logic [63:0] LFSR_TAPS_64  = 64'hD800_0000_0000_0000;
  localparam logic [63:0] LFSR_ZERO_SUB = 64'h1;

  // Maximal-length feedback masks for the supported widths. Any other width
  // returns 0, which degenerates to a plain shift register.
  function automatic logic [63:0] lfsr_taps(input int width);
    case (width)
      8:       return 64'h0000_0000_0000_00B8;
      16:      return 64'h0000_0000_0000_D008;
      32:      return 64'h0000_0000_8020_0003;
      64:      return LFSR_TAPS_64;
      default: return 64'h0;
    endcase
  endfunction

endpackage

// File: rtl/puf_challenge_gen_if.sv
// puf_challenge_gen_if: challenge hand-off between the generator and the
// evaluation/response logic.
//   challenge  - WIDTH-bit challenge driving the input-network dataIn
//   chal_valid - challenge has settled and may be evaluated
//   chal_ready - consumer has captured the response
//   chal_index - index of the current challenge within the burst
interface puf_challenge_gen_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] challenge;
  logic             chal_valid;
  logic             chal_ready;
  logic [CNT_W-1:0] chal_index;

  modport master (
    output challenge, chal_valid, chal_index,
    input  chal_ready
  );

  modport slave (
    input  challenge, chal_valid, chal_index,
    output chal_ready
  );
endinterface

// File: rtl/puf_lfsr_step.sv
// puf_lfsr_step: one step of a Fibonacci left-shift LFSR (purely combinational).
//   cur - current register value
//   nxt - value after one shift; the new LSB is the XOR of the tapped bits
module puf_lfsr_step
  import puf_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [63:0]      TAPS_ALL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

  assign nxt = {cur[WIDTH-2:0], ^(cur & TAPS)};

endmodule

// File: rtl/puf_challenge_gen.sv
// puf_challenge_gen: expands a seed into a burst of LFSR challenges for the
// PDL PUF input network, holding each one for SETTLE_CYCLES before offering
// it over a valid/ready handshake.
//   clk, rst_n       - clock, synchronous active-low reset
//   start            - one-cycle burst command, honoured only in IDLE
//   abort            - ends a burst immediately, highest priority
//   seed             - first challenge (zero is replaced by 1)
//   num_challenges   - burst length, 0 gives an immediate done pulse
//   busy             - high outside IDLE
//   done             - one-cycle pulse when a burst completes normally
//   chal             - challenge/valid/ready/index bundle (master side)
module puf_challenge_gen
  import puf_pkg::*;
#(
  parameter int WIDTH         = 64,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     seed,
  input  logic [CNT_W-1:0]     num_challenges,
  output logic                 busy,
  output logic                 done,
  puf_challenge_gen_if.master  chal
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] chal_q, chal_nxt, chal_step;
  logic [CNT_W-1:0] idx_q, idx_nxt;
  logic [CNT_W-1:0] num_q, num_nxt;
  logic [7:0]       cnt_q, cnt_nxt;

  puf_lfsr_step #(.WIDTH(WIDTH)) u_lfsr (
    .cur (chal_q),
    .nxt (chal_step)
  );

  // Every output is a decode of registered state, so chal_ready never has a
  // combinational path to chal_valid.
  assign chal.challenge  = chal_q;
  assign chal.chal_index = idx_q;
  assign chal.chal_valid = (state == PRESENT);
  assign busy            = (state != IDLE);
  assign done            = (state == DONE);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      chal_q <= '0;
      idx_q  <= '0;
      num_q  <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nxt;
      chal_q <= chal_nxt;
      idx_q  <= idx_nxt;
      num_q  <= num_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  // Next-state logic. Abort is checked first so it beats start and a
  // coincident handshake; challenge and index simply hold on abort.
  always_comb begin
    state_nxt = state;
    chal_nxt  = chal_q;
    idx_nxt   = idx_q;
    num_nxt   = num_q;
    cnt_nxt   = cnt_q;

    if (abort && state != IDLE) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            num_nxt = num_challenges;
            if (num_challenges != '0) begin
              chal_nxt  = (seed == '0) ? LFSR_ZERO_SUB[WIDTH-1:0] : seed;
              idx_nxt   = '0;
              cnt_nxt   = '0;
              state_nxt = SETTLE;
            end else begin
              state_nxt = DONE;
            end
          end
        end
        SETTLE: begin
          if (cnt_q == 8'(SETTLE_CYCLES - 1)) begin
            state_nxt = PRESENT;
          end else begin
            cnt_nxt = cnt_q + 8'd1;
          end
        end
        PRESENT: begin
          if (chal.chal_ready) begin
            // num_q is non-zero here, so num_q-1 cannot underflow and the
            // index never wraps even for the maximum burst length.
            if (idx_q == num_q - CNT_W'(1)) begin
              state_nxt = DONE;
            end else begin
              chal_nxt  = chal_step;
              idx_nxt   = idx_q + CNT_W'(1);
              cnt_nxt   = '0;
              state_nxt = SETTLE;
            end
          end
        end
        DONE: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_challenge_gen.sv
// tb_puf_challenge_gen: directed self-checking bench for puf_challenge_gen
// (WIDTH=64, CNT_W=16, SETTLE_CYCLES=16).
module tb_puf_challenge_gen;

  localparam int WIDTH  = 64;
  localparam int CNT_W  = 16;
  localparam int SETTLE = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] seed;
  logic [CNT_W-1:0] num_challenges;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  puf_challenge_gen_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) chal_if ();

  puf_challenge_gen #(
    .WIDTH         (WIDTH),
    .CNT_W         (CNT_W),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .seed           (seed),
    .num_challenges (num_challenges),
    .busy           (busy),
    .done           (done),
    .chal           (chal_if)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a start command; returns just after the edge that accepts it.
  task automatic launch(input logic [63:0] s, input logic [15:0] n);
    seed = s; num_challenges = n; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called right after the edge that loaded a challenge: valid must stay low
  // for SETTLE-1 more edges with the challenge stable, then rise.
  task automatic settle_check(input logic [63:0] exp_chal, input logic [15:0] exp_idx, input string name);
    for (int k = 1; k < SETTLE; k++) begin
      step();
      checks++; if (chal_if.chal_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s settle valid cyc %0d: got %b want 0", name, k, chal_if.chal_valid); end
      checks++; if (chal_if.challenge !== exp_chal) begin errors++; $display("[TB] FAIL %s settle chal cyc %0d: got %h want %h", name, k, chal_if.challenge, exp_chal); end
    end
    step();
    checks++; if (chal_if.chal_valid !== 1'b1) begin errors++; $display("[TB] FAIL %s valid rise: got %b want 1", name, chal_if.chal_valid); end
    checks++; if (chal_if.challenge !== exp_chal) begin errors++; $display("[TB] FAIL %s challenge: got %h want %h", name, chal_if.challenge, exp_chal); end
    checks++; if (chal_if.chal_index !== exp_idx) begin errors++; $display("[TB] FAIL %s index: got %0d want %0d", name, chal_if.chal_index, exp_idx); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed = '0; num_challenges = '0;
    chal_if.chal_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    checks++; if (chal_if.challenge !== 64'h0) begin errors++; $display("[TB] FAIL reset challenge: got %h want 0", chal_if.challenge); end
    checks++; if (chal_if.chal_index !== 16'h0) begin errors++; $display("[TB] FAIL reset index: got %0d want 0", chal_if.chal_index); end
    checks++; if (chal_if.chal_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset valid: got %b want 0", chal_if.chal_valid); end
    for (int k = 0; k < 10; k++) begin
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle busy cyc %0d: got %b want 0", k, busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL idle done cyc %0d: got %b want 0", k, done); end
    end
  endtask

  task automatic test_single();
    chal_if.chal_ready = 1'b1;
    launch(64'h1, 16'd1);
    checks++; if (chal_if.challenge !== 64'h1) begin errors++; $display("[TB] FAIL single load: got %h want 1", chal_if.challenge); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single busy: got %b want 1", busy); end
    settle_check(64'h1, 16'd0, "single");
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL single done: got %b want 1", done); end
    checks++; if (chal_if.chal_valid !== 1'b0) begin errors++; $display("[TB] FAIL single valid drop: got %b want 0", chal_if.chal_valid); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL single done width: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single busy after: got %b want 0", busy); end
  endtask

  task automatic test_lfsr_sequence();
    logic [63:0] exp_seq [3];
    exp_seq[0] = 64'h8000_0000_0000_0000;
    exp_seq[1] = 64'h1;
    exp_seq[2] = 64'h2;
    chal_if.chal_ready = 1'b1;
    launch(64'h8000_0000_0000_0000, 16'd3);
    for (int i = 0; i < 3; i++) begin
      checks++; if (chal_if.challenge !== exp_seq[i]) begin errors++; $display("[TB] FAIL lfsr load %0d: got %h want %h", i, chal_if.challenge, exp_seq[i]); end
      settle_check(exp_seq[i], 16'(i), "lfsr");
      step();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL lfsr done: got %b want 1", done); end
    step();
  endtask

  task automatic test_backpressure_zero_seed();
    chal_if.chal_ready = 1'b0;
    launch(64'h0, 16'd2);
    checks++; if (chal_if.challenge !== 64'h1) begin errors++; $display("[TB] FAIL zero seed: got %h want 1", chal_if.challenge); end
    settle_check(64'h1, 16'd0, "bp");
    for (int k = 0; k < 50; k++) begin
      step();
      checks++; if (chal_if.chal_valid !== 1'b1 || chal_if.challenge !== 64'h1) begin errors++; $display("[TB] FAIL bp hold cyc %0d: got valid %b chal %h want 1 / 1", k, chal_if.chal_valid, chal_if.challenge); end
    end
    chal_if.chal_ready = 1'b1;
    step();
    checks++; if (chal_if.challenge !== 64'h2) begin errors++; $display("[TB] FAIL bp next: got %h want 2", chal_if.challenge); end
    checks++; if (chal_if.chal_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp valid drop: got %b want 0", chal_if.chal_valid); end
    settle_check(64'h2, 16'd1, "bp2");
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL bp done: got %b want 1", done); end
    step();
  endtask

  task automatic test_edge_commands();
    chal_if.chal_ready = 1'b1;
    launch(64'h1234, 16'd0);
    checks++; if (done !== 1'b1 || chal_if.chal_valid !== 1'b0) begin errors++; $display("[TB] FAIL num0: got done %b valid %b want 1 / 0", done, chal_if.chal_valid); end
    checks++; if (chal_if.challenge !== 64'h2) begin errors++; $display("[TB] FAIL num0 challenge held: got %h want 2", chal_if.challenge); end
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL num0 end: got done %b busy %b want 0 / 0", done, busy); end
    // Start pulsed mid-settle must not reload anything.
    launch(64'h8000_0000_0000_0000, 16'd3);
    repeat (4) step();
    seed = 64'h5; num_challenges = 16'd1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (SETTLE - 6) step();
    checks++; if (chal_if.chal_valid !== 1'b0) begin errors++; $display("[TB] FAIL busy start early valid: got %b want 0", chal_if.chal_valid); end
    step();
    checks++; if (chal_if.chal_valid !== 1'b1 || chal_if.challenge !== 64'h8000_0000_0000_0000) begin errors++; $display("[TB] FAIL busy start present: got valid %b chal %h want 1 / 8000000000000000", chal_if.chal_valid, chal_if.challenge); end
    step();
    checks++; if (chal_if.chal_index !== 16'd1 || chal_if.challenge !== 64'h1) begin errors++; $display("[TB] FAIL busy start next: got idx %0d chal %h want 1 / 1", chal_if.chal_index, chal_if.challenge); end
    abort = 1'b1; step(); abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cleanup abort busy: got %b want 0", busy); end
  endtask

  task automatic test_abort();
    chal_if.chal_ready = 1'b1;
    launch(64'h8000_0000_0000_0000, 16'd5);
    settle_check(64'h8000_0000_0000_0000, 16'd0, "abort");
    step();
    repeat (3) step();
    abort = 1'b1; step(); abort = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || chal_if.chal_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort settle: got busy %b done %b valid %b want 0 0 0", busy, done, chal_if.chal_valid); end
    checks++; if (chal_if.challenge !== 64'h1 || chal_if.chal_index !== 16'd1) begin errors++; $display("[TB] FAIL abort hold: got chal %h idx %0d want 1 / 1", chal_if.challenge, chal_if.chal_index); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort late done: got %b want 0", done); end
    // Abort coincident with a handshake wins.
    chal_if.chal_ready = 1'b0;
    launch(64'h8000_0000_0000_0000, 16'd5);
    settle_check(64'h8000_0000_0000_0000, 16'd0, "abort_hs");
    chal_if.chal_ready = 1'b1; abort = 1'b1; step(); abort = 1'b0;
    checks++; if (busy !== 1'b0 || chal_if.chal_index !== 16'd0 || chal_if.challenge !== 64'h8000_0000_0000_0000) begin errors++; $display("[TB] FAIL abort vs hs: got busy %b idx %0d chal %h want 0 / 0 / 8000000000000000", busy, chal_if.chal_index, chal_if.challenge); end
    // Abort together with start in IDLE suppresses the start.
    seed = 64'h7; num_challenges = 16'd1; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0 || chal_if.challenge !== 64'h8000_0000_0000_0000) begin errors++; $display("[TB] FAIL abort+start: got busy %b chal %h want 0 / 8000000000000000", busy, chal_if.challenge); end
  endtask

  task automatic test_reset_mid_burst();
    chal_if.chal_ready = 1'b0;
    launch(64'h8000_0000_0000_0000, 16'd5);
    settle_check(64'h8000_0000_0000_0000, 16'd0, "rst_mid");
    rst_n = 1'b0; step(); rst_n = 1'b1;
    checks++; if (chal_if.challenge !== 64'h0 || chal_if.chal_index !== 16'd0) begin errors++; $display("[TB] FAIL rst mid data: got chal %h idx %0d want 0 / 0", chal_if.challenge, chal_if.chal_index); end
    checks++; if (chal_if.chal_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL rst mid ctrl: got valid %b busy %b done %b want 0 0 0", chal_if.chal_valid, busy, done); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst mid late done: got %b want 0", done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_lfsr_sequence();
    test_backpressure_zero_seed();
    test_edge_commands();
    test_abort();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
